// File: rtl/booth_mul_pkg.sv
// Shared Booth digit encodings and row-building helpers for booth_mul_pipe.
// Supports operand widths up to 64 bits.
package booth_mul_pkg;

    typedef logic [2:0] booth_dig_t;

    localparam booth_dig_t BD_ZERO = 3'b000;
    localparam booth_dig_t BD_P1   = 3'b001;
    localparam booth_dig_t BD_P2   = 3'b010;
    localparam booth_dig_t BD_N1   = 3'b101;
    localparam booth_dig_t BD_N2   = 3'b110;

    localparam int PKG_MAXW = 128;
    localparam int PKG_IW   = $clog2(PKG_MAXW);

    function automatic int npp(input int w);
        return w / 2 + 1;
    endfunction

    function automatic booth_dig_t booth_digit(input logic [2:0] trip);
        booth_dig_t d;
        case (trip)
            3'b001, 3'b010: d = BD_P1;
            3'b011:         d = BD_P2;
            3'b100:         d = BD_N2;
            3'b101, 3'b110: d = BD_N1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

    // Sign-extend a row_w-bit two's-complement row and shift it left by sh.
    function automatic logic [PKG_MAXW-1:0] ext_shift(
        input logic [PKG_MAXW-1:0] row,
        input int                  row_w,
        input int                  sh
    );
        logic [PKG_MAXW-1:0] r;
        logic [PKG_IW-1:0]   msb;
        int                  s;
        r   = '0;
        msb = PKG_IW'(row_w - 1);
        for (int i = 0; i < PKG_MAXW; i++) begin
            s = i - sh;
            if (s < 0) begin
                r[i[PKG_IW-1:0]] = 1'b0;
            end else if (s >= row_w) begin
                r[i[PKG_IW-1:0]] = row[msb];
            end else begin
                r[i[PKG_IW-1:0]] = row[s[PKG_IW-1:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_mul_pipe_csa.sv
// Combinational Wallace reduction of NPP partial-product rows to sum/carry.
// Each level groups rows in threes into full-adder rows; leftovers pass through.
module booth_csa_tree
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NPP   = 17
) (
    input  logic [NPP-1:0][2*WIDTH-1:0] rows_i,
    output logic [2*WIDTH-1:0]          sum_o,
    output logic [2*WIDTH-1:0]          carry_o
);

    localparam int PW = 2 * WIDTH;

    function automatic int rows_at(input int lvl);
        int r;
        r = NPP;
        for (int i = 0; i < lvl; i++) begin
            r = 2 * (r / 3) + r % 3;
        end
        return r;
    endfunction

    function automatic int nlev();
        int r;
        int n;
        r = NPP;
        n = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            n++;
        end
        return n;
    endfunction

    function automatic int offs(input int lvl);
        int o;
        o = 0;
        for (int i = 0; i < lvl; i++) begin
            o += rows_at(i);
        end
        return o;
    endfunction

    localparam int NLEV = nlev();
    localparam int NTOT = offs(NLEV) + 2;

    // All levels live in one flat node array; level l starts at offs(l).
    logic [NTOT-1:0][PW-1:0] node;

    for (genvar i = 0; i < NPP; i++) begin : g_in
        assign node[i] = rows_i[i];
    end

    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        localparam int R  = rows_at(l);
        localparam int G  = R / 3;
        localparam int IB = offs(l);
        localparam int OB = offs(l + 1);

        for (genvar g = 0; g < G; g++) begin : g_fa
            logic [PW-1:0] a;
            logic [PW-1:0] b;
            logic [PW-1:0] c;
            logic [PW-1:0] maj;
            assign a   = node[IB + 3*g];
            assign b   = node[IB + 3*g + 1];
            assign c   = node[IB + 3*g + 2];
            assign maj = (a & b) | (a & c) | (b & c);
            assign node[OB + 2*g]     = a ^ b ^ c;
            assign node[OB + 2*g + 1] = maj << 1;
        end

        for (genvar j = 0; j < R - 3*G; j++) begin : g_pass
            assign node[OB + 2*G + j] = node[IB + 3*G + j];
        end
    end

    assign sum_o   = node[NTOT-2];
    assign carry_o = node[NTOT-1];

endmodule

// File: rtl/booth_mul_pipe.sv
// 3-stage radix-4 Booth / Wallace multiplier with valid/ready stream ports.
// Define BOOTH_MUL_ACC_EN to add the in_acc port and output accumulator.
module booth_mul_pipe
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef BOOTH_MUL_ACC_EN
    input  logic               in_acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int NPP = npp(WIDTH);
    localparam int PW  = 2 * WIDTH;
    localparam int RW  = WIDTH + 3;

    logic adv1;
    logic adv2;
    logic adv3;

    logic v1_q;
    logic v2_q;
    logic v3_q;

    logic [NPP-1:0][PW-1:0] rows_d;
    logic [NPP-1:0][PW-1:0] rows_q;
    logic [TAG_W-1:0]       tag1_q;

    logic [PW-1:0]          sum_d;
    logic [PW-1:0]          carry_d;
    logic [PW-1:0]          sum_q;
    logic [PW-1:0]          carry_q;
    logic [TAG_W-1:0]       tag2_q;

    logic [PW-1:0]          p_d;
    logic [PW-1:0]          p_q;
    logic [TAG_W-1:0]       tag3_q;

    assign adv3     = !v3_q || out_ready;
    assign adv2     = !v2_q || adv3;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    // S1: Booth recode with operands extended to WIDTH+2 bits.
    logic [WIDTH+1:0] xe;
    logic [WIDTH+2:0] yz;
    logic [RW-1:0]    x1;
    logic [RW-1:0]    x2;

    assign xe = {{2{in_signed & in_x[WIDTH-1]}}, in_x};
    assign yz = {{2{in_signed & in_y[WIDTH-1]}}, in_y, 1'b0};
    assign x1 = {xe[WIDTH+1], xe};
    assign x2 = {xe, 1'b0};

    for (genvar k = 0; k < NPP; k++) begin : g_row
        booth_dig_t    dig;
        logic [RW-1:0] mag;

        assign dig = booth_digit(yz[2*k+2:2*k]);

        always_comb begin
            mag = '0;
            unique case (dig)
                BD_P1:   mag = x1;
                BD_P2:   mag = x2;
                BD_N1:   mag = ~x1 + RW'(1);
                BD_N2:   mag = ~x2 + RW'(1);
                default: mag = '0;
            endcase
        end

        assign rows_d[k] = PW'(ext_shift(PKG_MAXW'(mag), RW, 2*k));
    end

    // S2: carry-save reduction of the registered rows.
    booth_csa_tree #(
        .WIDTH (WIDTH),
        .NPP   (NPP)
    ) u_csa (
        .rows_i  (rows_q),
        .sum_o   (sum_d),
        .carry_o (carry_d)
    );

    // S3: carry-propagate add, optionally folding in the accumulator.
`ifdef BOOTH_MUL_ACC_EN
    logic          acc1_q;
    logic          acc2_q;
    logic [PW-1:0] acc_q;
    logic [PW-1:0] acc_src;

    // S3 only loads with a full output stage when that product is leaving,
    // so the value being emitted this cycle is the one to accumulate.
    assign acc_src = v3_q ? p_q : acc_q;
    assign p_d     = sum_q + carry_q + (acc2_q ? acc_src : '0);

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            acc1_q <= in_acc;
        end
        if (adv2 && v1_q) begin
            acc2_q <= acc1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (v3_q && out_ready) begin
            acc_q <= p_q;
        end
    end
`else
    assign p_d = sum_q + carry_q;
`endif

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            rows_q <= rows_d;
            tag1_q <= in_tag;
        end
        if (adv2 && v1_q) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            tag2_q  <= tag1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            p_q    <= '0;
            tag3_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
            end
            if (adv2) begin
                v2_q <= v1_q;
            end
            if (adv3) begin
                v3_q <= v2_q;
            end
            if (adv3 && v2_q) begin
                p_q    <= p_d;
                tag3_q <= tag2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_p     = p_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Self-checking bench for booth_mul_pipe: directed table, random stream,
// back-pressure and reset sequences against a plain-arithmetic scoreboard.
module tb_booth_mul_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
`ifdef BOOTH_MUL_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic           s;
        logic [TW-1:0]  tag;
        logic           acc;
        logic [2*W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] prod;
        logic [TW-1:0]  tag;
        logic           acc;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic           in_signed;
    logic [TW-1:0]  in_tag;
    logic           acc_r;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic [TW-1:0]  out_tag;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_out    = 0;
    sb_t            sb[$];
    logic [2*W-1:0] exp_acc  = '0;

    always #5 clk = ~clk;

    booth_mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_signed (in_signed),
        .in_tag    (in_tag),
`ifdef BOOTH_MUL_ACC_EN
        .in_acc    (acc_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint          sa, sb_;
        longint unsigned ua, ub;
        if (s) begin
            sa  = longint'($signed(x));
            sb_ = longint'($signed(y));
            return sa * sb_;
        end
        ua = {32'd0, x};
        ub = {32'd0, y};
        return ua * ub;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                input logic [TW-1:0] tag, input logic acc,
                                input logic [2*W-1:0] exp);
        vec_t v;
        v.x = x; v.y = y; v.s = s; v.tag = tag; v.acc = acc; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        in_x      = $urandom;
        in_y      = $urandom;
        if ($urandom_range(0, 7) == 0) in_x = 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) in_y = 32'hFFFF_FFFF;
        in_signed = 1'($urandom_range(0, 1));
        in_tag    = TW'($urandom);
        acc_r     = ACC_EN ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // Single isolated transaction: checks acceptance, latency, product, tag.
    task automatic run_one(input vec_t v, input string name);
        int lat;
        bit seen;
        tick();
        in_valid = 1'b1; in_x = v.x; in_y = v.y; in_signed = v.s;
        in_tag = v.tag; acc_r = v.acc;
        #1;
        check({name, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            if (out_valid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check({name, " latency"}, 64'(lat), 3);
        check({name, " p"}, out_p, v.exp);
        check({name, " tag"}, out_tag, v.tag);
    endtask

    // Scoreboard: transfers are decided by the values stable at the falling edge.
    always @(negedge clk) begin : mon
        sb_t            e;
        logic [2*W-1:0] ev;
        if (rst) begin
            sb.delete();
            exp_acc = '0;
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected output", out_valid, 0);
                end else begin
                    e  = sb.pop_front();
                    ev = e.prod + ((ACC_EN && e.acc) ? exp_acc : '0);
                    exp_acc = ev;
                    check("stream p", out_p, ev);
                    check("stream tag", out_tag, e.tag);
                end
            end
            if (in_valid && in_ready) begin
                e.prod = ref_mul(in_x, in_y, in_signed);
                e.tag  = in_tag;
                e.acc  = acc_r;
                sb.push_back(e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   n0;
        int   acc_cnt;
        bit   got;
        int   not_ready;
        logic [2*W-1:0] held_p;
        logic [TW-1:0]  held_t;

        vecs[0]  = mk(32'd7,         32'hFFFF_FFFD, 1, 4'd5,  0, 64'hFFFF_FFFF_FFFF_FFEB);
        vecs[1]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 4'd1,  0, 64'hFFFF_FFFE_0000_0001);
        vecs[2]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 4'd2,  0, 64'h0000_0000_0000_0001);
        vecs[3]  = mk(32'h8000_0000, 32'h8000_0000, 1, 4'd3,  0, 64'h4000_0000_0000_0000);
        vecs[4]  = mk(32'h8000_0000, 32'h8000_0000, 0, 4'd4,  0, 64'h4000_0000_0000_0000);
        vecs[5]  = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 4'd6,  0, 64'h3FFF_FFFF_0000_0001);
        vecs[6]  = mk(32'h8000_0000, 32'd2,         1, 4'd7,  0, 64'hFFFF_FFFF_0000_0000);
        vecs[7]  = mk(32'h8000_0000, 32'd2,         0, 4'd8,  0, 64'h0000_0001_0000_0000);
        vecs[8]  = mk(32'd1,         32'hFFFF_FFFF, 1, 4'd9,  0, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[9]  = mk(32'd1,         32'hFFFF_FFFF, 0, 4'd10, 0, 64'h0000_0000_FFFF_FFFF);
        vecs[10] = mk(32'd0,         32'hDEAD_BEEF, 1, 4'd11, 0, 64'h0);
        vecs[11] = mk(32'hFFFF_FFFF, 32'h8000_0000, 1, 4'd15, 0, 64'h0000_0000_8000_0000);

        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0;
        in_tag = '0; acc_r = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("reset out_valid", out_valid, 0);
        check("reset out_p", out_p, 0);
        check("reset out_tag", out_tag, 0);
        rst = 1'b0;
        tick();
        check("in_ready after reset", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef BOOTH_MUL_ACC_EN
        run_one(mk(32'd3, 32'd4, 0, 4'd1, 0, 64'd12), "acc first");
        run_one(mk(32'd5, 32'd6, 0, 4'd2, 1, 64'd42), "acc second");
        run_one(mk(32'h8000_0000, 32'h8000_0000, 1, 4'd3, 0, 64'h4000_0000_0000_0000),
                "acc plain");
`endif

        // Back-to-back random stream with the consumer always ready.
        tick();
        n0 = n_out;
        not_ready = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            in_valid = 1'b1;
            drive_rand();
            #1;
            if (!in_ready) not_ready++;
        end
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("stream never stalled", 64'(not_ready), 0);
        check("stream one per cycle", 64'(n_out - n0), 100);
        check("stream sb empty", 64'(sb.size()), 0);

        // Back-pressure: consumer stalls for 6 cycles under a continuous stream.
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_rand();
        n0 = n_out;
        acc_cnt = 0;
        held_p = '0;
        held_t = '0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (cyc >= 3) check($sformatf("stall in_ready c%0d", cyc), in_ready, 0);
            if (cyc == 3) begin
                check("stall out_valid", out_valid, 1);
                held_p = out_p;
                held_t = out_tag;
            end
            if (cyc > 3) begin
                check($sformatf("stall held p c%0d", cyc), out_p, held_p);
                check($sformatf("stall held tag c%0d", cyc), out_tag, held_t);
            end
            got = in_ready;
            if (got) acc_cnt++;
            tick();
            if (got) drive_rand();
        end
        check("stall accepts", 64'(acc_cnt), 3);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && acc_cnt < 10; cyc++) begin
            #1;
            got = in_ready;
            if (got) acc_cnt++;
            tick();
            if (got) begin
                if (acc_cnt < 10) drive_rand();
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) tick();
        check("stall delivered", 64'(n_out - n0), 10);
        check("stall sb empty", 64'(sb.size()), 0);

        // Reset with three products in flight.
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            tick();
        end
        in_valid = 1'b0;
        check("flush pipe full", out_valid, 1);
        rst = 1'b1;
        tick();
        check("flush out_valid", out_valid, 0);
        check("flush out_p", out_p, 0);
        check("flush out_tag", out_tag, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        not_ready = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) not_ready++;
        end
        check("flush no stale output", 64'(not_ready), 0);
        check("flush in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
